// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: run/single-step controller for a CPU core on the free-running board clock.
// Drives a registered clock-enable (never a gated clock), stretches the core reset, counts steps.

module cpu_clk_ctrl_db #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   DB_CNT_W        = 19,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);
  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]          sync_pipe;
  logic                synced;
  logic [DB_CNT_W-1:0] cnt;

  assign synced = sync_pipe[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_pipe <= {2{RST_VAL}};
    else      sync_pipe <= {sync_pipe[0], raw};
  end

  // Any sample agreeing with db restarts the run, so only an unbroken run is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db  <= RST_VAL;
      cnt <= '0;
    end else if (synced == db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      db  <= synced;
      cnt <= '0;
    end else begin
      cnt <= cnt + DB_CNT_W'(1);
    end
  end
endmodule

module cpu_clk_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_CNT_W        = 19,
  parameter int RST_HOLD        = 16,
  parameter int STEP_CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_step_n,
  input  logic                  sw_step_mode,
  output logic                  cpu_en,
  output logic                  cpu_rst,
  output logic                  step_mode,
  output logic [STEP_CNT_W-1:0] step_count
);
  localparam int NUM_IN = 2;
  localparam int KEY    = 0;
  localparam int MODE   = 1;
  // Key idles released (1), mode idles free-run (0)
  localparam logic [NUM_IN-1:0] IN_RST = 2'b01;
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    S_RST_HOLD,
    S_RUN,
    S_STEP_IDLE,
    S_STEP_PULSE,
    S_STEP_WAIT_REL
  } state_t;

  logic [NUM_IN-1:0] raw_in, db_in;
  logic              db_key, db_mode, db_key_q, key_fall;
  state_t            state, nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              en_d, rst_d, step_inc;

  assign raw_in = {sw_step_mode, key_step_n};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_db
    cpu_clk_ctrl_db #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_CNT_W        (DB_CNT_W),
      .RST_VAL         (IN_RST[i])
    ) u_db (
      .clk (clk),
      .rst (rst),
      .raw (raw_in[i]),
      .db  (db_in[i])
    );
  end

  assign db_key    = db_in[KEY];
  assign db_mode   = db_in[MODE];
  assign key_fall  = !db_key && db_key_q;
  assign step_mode = db_mode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_RST_HOLD;
      hold_cnt   <= '0;
      db_key_q   <= 1'b1;
      cpu_en     <= 1'b0;
      cpu_rst    <= 1'b1;
      step_count <= '0;
    end else begin
      state    <= nxt;
      db_key_q <= db_key;
      hold_cnt <= (state == S_RST_HOLD) ? hold_cnt + HOLD_W'(1) : '0;
      cpu_en   <= en_d;
      cpu_rst  <= rst_d;
      if (step_inc) step_count <= step_count + STEP_CNT_W'(1);
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_RST_HOLD:      if (hold_cnt == HOLD_LAST) nxt = db_mode ? S_STEP_IDLE : S_RUN;
      S_RUN:           if (db_mode) nxt = S_STEP_IDLE;
      // A press wins over a simultaneous mode change; the mode is picked up after the pulse
      S_STEP_IDLE:     if (key_fall) nxt = S_STEP_PULSE;
                       else if (!db_mode) nxt = S_RUN;
      S_STEP_PULSE:    nxt = S_STEP_WAIT_REL;
      S_STEP_WAIT_REL: if (!db_mode) nxt = S_RUN;
                       else if (db_key) nxt = S_STEP_IDLE;
      default:         nxt = S_RST_HOLD;
    endcase
  end

  // Outputs decode the next state so they line up with the state register
  always_comb begin
    en_d     = (nxt == S_RUN) || (nxt == S_STEP_PULSE);
    rst_d    = (nxt == S_RST_HOLD);
    step_inc = (nxt == S_STEP_PULSE);
  end
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: directed scenarios with literal checks, plus a per-cycle
// comparison against a behavioural model built from the debounce/step rules.
module tb_cpu_clk_ctrl;
  localparam int DB   = 4;
  localparam int HOLD = 3;
  localparam int SCW  = 4;

  logic           clk = 1'b0;
  logic           rst, key_step_n, sw_step_mode;
  logic           cpu_en, cpu_rst, step_mode;
  logic [SCW-1:0] step_count;

  int errors = 0, checks = 0;
  int cyc = 0, rises = 0, en_hi = 0;
  logic en_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_clk_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .DB_CNT_W        (3),
    .RST_HOLD        (HOLD),
    .STEP_CNT_W      (SCW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_step_n   (key_step_n),
    .sw_step_mode (sw_step_mode),
    .cpu_en       (cpu_en),
    .cpu_rst      (cpu_rst),
    .step_mode    (step_mode),
    .step_count   (step_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Model: an input is accepted once its last DB synchronised samples (raw seen 2+ edges ago)
  // all disagree with the accepted value. Control: hold, run, or step (idle/pulse/await release).
  logic [DB:0] kh, mh;
  logic        m_dbk, m_dbk_q, m_dbm;
  logic        m_run, m_pulse, m_wait;
  int          hold_left, m_count;
  logic        m_fall, exp_en, exp_rst;

  assign m_fall  = !m_dbk && m_dbk_q;
  assign exp_en  = m_run || m_pulse;
  assign exp_rst = (hold_left > 0);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      kh <= '1; mh <= '0;
      m_dbk <= 1'b1; m_dbk_q <= 1'b1; m_dbm <= 1'b0;
      hold_left <= HOLD; m_run <= 1'b0; m_pulse <= 1'b0; m_wait <= 1'b0; m_count <= 0;
    end else begin
      if (hold_left > 0) begin
        hold_left <= hold_left - 1;
        if (hold_left == 1) m_run <= !m_dbm;
      end else if (m_run) begin
        m_run <= !m_dbm;
      end else if (m_pulse) begin
        m_pulse <= 1'b0; m_wait <= 1'b1;
      end else if (m_wait) begin
        if (!m_dbm) begin m_wait <= 1'b0; m_run <= 1'b1; end
        else if (m_dbk) m_wait <= 1'b0;
      end else if (m_fall) begin
        m_pulse <= 1'b1; m_count <= (m_count + 1) % (1 << SCW);
      end else if (!m_dbm) begin
        m_run <= 1'b1;
      end
      m_dbk_q <= m_dbk;
      m_dbk   <= (kh[DB:1] == {DB{~m_dbk}}) ? ~m_dbk : m_dbk;
      m_dbm   <= (mh[DB:1] == {DB{~m_dbm}}) ? ~m_dbm : m_dbm;
      kh      <= {kh[DB-1:0], key_step_n};
      mh      <= {mh[DB-1:0], sw_step_mode};
    end
  end

  always @(negedge clk) begin
    chk("model cpu_en", int'(cpu_en), int'(exp_en));
    chk("model cpu_rst", int'(cpu_rst), int'(exp_rst));
    chk("model step_mode", int'(step_mode), int'(m_dbm));
    chk("model step_count", int'(step_count), m_count);
    if (cpu_en && !en_prev) rises <= rises + 1;
    if (cpu_en) en_hi <= en_hi + 1;
    en_prev <= cpu_en;
  end

  initial begin
    int r0, h0, k, t_en;
    logic found;
    rst = 1'b1; key_step_n = 1'b1; sw_step_mode = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("reset cpu_en", int'(cpu_en), 0);
    chk("reset cpu_rst", int'(cpu_rst), 1);
    chk("reset step_count", int'(step_count), 0);
    chk("reset step_mode", int'(step_mode), 0);

    // 1: reset stretch then free-run
    ticks(2);
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t1 cpu_rst", int'(cpu_rst), int'(i < 3));
      chk("t1 cpu_en", int'(cpu_en), int'(i == 3));
    end
    ticks(5);
    chk("t1 run cpu_en", int'(cpu_en), 1);
    chk("t1 step_count", int'(step_count), 0);

    // 2: single clean press, latency 2 sync + DB + 1
    sw_step_mode = 1'b1;
    ticks(10);
    chk("t2 step_mode", int'(step_mode), 1);
    chk("t2 idle cpu_en", int'(cpu_en), 0);
    r0 = rises; h0 = en_hi;
    key_step_n = 1'b0; k = cyc; t_en = -1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (cpu_en && t_en < 0) t_en = cyc - k;
    end
    chk("t2 latency", t_en, 7);
    ticks(5);
    key_step_n = 1'b1;
    ticks(10);
    chk("t2 pulses", rises - r0, 1);
    chk("t2 width", en_hi - h0, 1);
    chk("t2 step_count", int'(step_count), 1);

    // 3: bounce shorter than the debounce window
    r0 = rises;
    for (int i = 0; i < 3; i++) begin
      key_step_n = 1'b0; ticks(2);
      key_step_n = 1'b1; ticks(2);
    end
    ticks(10);
    chk("t3 pulses", rises - r0, 0);
    chk("t3 step_count", int'(step_count), 1);

    // 4: fresh reset, 17 presses wrap the counter
    rst = 1'b0; ticks(2); rst = 1'b1;
    ticks(15);
    chk("t4 step_mode", int'(step_mode), 1);
    chk("t4 idle cpu_en", int'(cpu_en), 0);
    chk("t4 step_count0", int'(step_count), 0);
    r0 = rises; h0 = en_hi;
    for (int i = 1; i <= 17; i++) begin
      key_step_n = 1'b0; ticks(10);
      key_step_n = 1'b1; ticks(10);
      if (i == 15) chk("t4 count15", int'(step_count), 15);
      if (i == 16) chk("t4 count wrap", int'(step_count), 0);
    end
    chk("t4 pulses", rises - r0, 17);
    chk("t4 width", en_hi - h0, 17);
    chk("t4 step_count", int'(step_count), 1);

    // 5: key already held when step mode is entered
    sw_step_mode = 1'b0; ticks(12);
    chk("t5 run cpu_en", int'(cpu_en), 1);
    key_step_n = 1'b0; ticks(12);
    sw_step_mode = 1'b1; ticks(12);
    chk("t5 step_mode", int'(step_mode), 1);
    chk("t5 idle cpu_en", int'(cpu_en), 0);
    r0 = rises;
    ticks(10);
    key_step_n = 1'b1; ticks(12);
    chk("t5 held no pulse", rises - r0, 0);
    key_step_n = 1'b0; ticks(12);
    chk("t5 repress pulse", rises - r0, 1);
    chk("t5 step_count", int'(step_count), 2);
    key_step_n = 1'b1; ticks(12);
    sw_step_mode = 1'b0; ticks(12);
    found = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!cpu_en) found = 1'b0;
    end
    chk("t5 run continuous", int'(found), 1);

    // 6: reset during the step pulse
    sw_step_mode = 1'b1; ticks(12);
    chk("t6 step_mode", int'(step_mode), 1);
    key_step_n = 1'b0; found = 1'b0;
    for (int i = 0; i < 15 && !found; i++) begin
      tick();
      found = cpu_en;
    end
    chk("t6 pulse seen", int'(found), 1);
    #2 rst = 1'b0;
    #1;
    chk("t6 async cpu_en", int'(cpu_en), 0);
    chk("t6 async cpu_rst", int'(cpu_rst), 1);
    chk("t6 step_count", int'(step_count), 0);
    key_step_n = 1'b1;
    ticks(2);
    rst = 1'b1;
    ticks(15);
    chk("t6 recover cpu_rst", int'(cpu_rst), 0);
    chk("t6 recover mode", int'(step_mode), 1);
    chk("t6 recover cpu_en", int'(cpu_en), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
